// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S types and default geometry
package i2s_pkg;

  localparam int I2S_DATA_W = 16;
  localparam int I2S_SLOT_W = 32;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_s;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCK divider with fall-event strobe
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic fall
);

  // CLK_DIV=1 still needs a one-bit counter that simply sits at zero
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);
  // a tick while sck is high is the 1->0 edge the framing logic works on
  assign fall = tick & sck;

  // half-period counter; sck toggles on every wrap, first toggle is a rise
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter: framing, sample buffers, serialiser
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = I2S_DATA_W,
  parameter int SLOT_W  = I2S_SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data_l,
  input  logic [DATA_W-1:0] s_data_r,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BW      = $clog2(FRAME_W);
  localparam int IW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

  logic              bck_fall;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_nxt;
  logic              frame_wrap;
  chan_e             chan_nxt;
  int                slot_bit;
  logic [IW-1:0]     bit_idx;
  logic              sd_nxt;
  logic              accept;
  logic              pend_valid;
  logic              pend_valid_nxt;
  logic [DATA_W-1:0] pend_l;
  logic [DATA_W-1:0] pend_r;
  logic [DATA_W-1:0] act_l;
  logic [DATA_W-1:0] act_r;

  i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .sck (sck),
    .fall(bck_fall)
  );

  // position in the frame after the coming fall, and the bit to present there
  always_comb begin
    bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    frame_wrap = bck_fall && (bit_cnt == BIT_LAST);
    chan_nxt   = (int'(bit_nxt) >= SLOT_W) ? CH_R : CH_L;
    slot_bit   = (chan_nxt == CH_R) ? int'(bit_nxt) - SLOT_W : int'(bit_nxt);
    bit_idx    = IW'(DATA_W - slot_bit);
    sd_nxt     = 1'b0;
    // slot bit 0 is the one-BCK I2S delay; the active words only reload on
    // that bit, so reading the old buffers here is always correct
    if (slot_bit >= 1 && slot_bit <= DATA_W) begin
      sd_nxt = (chan_nxt == CH_R) ? act_r[bit_idx] : act_l[bit_idx];
    end
  end

  // pending slot: frame start empties it, an accept fills it (never both)
  always_comb begin
    accept         = s_valid & s_ready;
    pend_valid_nxt = pend_valid;
    if (frame_wrap) begin
      pend_valid_nxt = 1'b0;
    end
    if (accept) begin
      pend_valid_nxt = 1'b1;
    end
  end

  // frame counter, line outputs, buffers and handshake state
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      bit_cnt     <= BIT_LAST;
      ws          <= 1'b1;
      sd          <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      s_ready     <= 1'b1;
      pend_valid  <= 1'b0;
      pend_l      <= '0;
      pend_r      <= '0;
      act_l       <= '0;
      act_r       <= '0;
    end else begin
      frame_start <= frame_wrap;
      underrun    <= frame_wrap & ~pend_valid;
      if (bck_fall) begin
        bit_cnt <= bit_nxt;
        ws      <= (chan_nxt == CH_R);
        sd      <= sd_nxt;
      end
      // an empty pending slot at frame start mutes the whole frame
      if (frame_wrap) begin
        act_l <= pend_valid ? pend_l : '0;
        act_r <= pend_valid ? pend_r : '0;
      end
      if (accept) begin
        pend_l <= s_data_l;
        pend_r <= s_data_r;
      end
      pend_valid <= pend_valid_nxt;
      s_ready    <= ~pend_valid_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized bench for i2s_tx against a frame-arithmetic model
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        s_valid;
  logic [15:0] s_data_l;
  logic [15:0] s_data_r;
  logic [1:0]  sck, ws, sd, fs, ur, rdy;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int ur_dut = 0, ur_mod = 0, fs_dut = 0, fs_mod = 0;

  // model state, index 0: CLK_DIV=4/SLOT_W=32, index 1: CLK_DIV=1/SLOT_W=17
  int          k[2];
  logic        pv[2];
  logic [15:0] pl[2], pr[2], cl[2], cr[2];
  logic        e_sck[2], e_ws[2], e_sd[2], e_fs[2], e_ur[2], e_rdy[2];

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(4), .DATA_W(16), .SLOT_W(32)) dut0 (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(rdy[0]),
    .s_data_l(s_data_l), .s_data_r(s_data_r), .sck(sck[0]), .ws(ws[0]),
    .sd(sd[0]), .frame_start(fs[0]), .underrun(ur[0])
  );

  i2s_tx #(.CLK_DIV(1), .DATA_W(16), .SLOT_W(17)) dut1 (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(rdy[1]),
    .s_data_l(s_data_l), .s_data_r(s_data_r), .sck(sck[1]), .ws(ws[1]),
    .sd(sd[1]), .frame_start(fs[1]), .underrun(ur[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int cdiv(input bit i);
    return i ? 1 : 4;
  endfunction

  function automatic int slotw(input bit i);
    return i ? 17 : 32;
  endfunction

  // true when the next clk edge is a frame start for instance i
  function automatic bit fs_next(input bit i);
    int kk, tg;
    kk = k[i] + 1;
    tg = kk / cdiv(i);
    return (kk % cdiv(i) == 0) && (tg % 2 == 0) && (((tg / 2) - 1) % (2 * slotw(i)) == 0);
  endfunction

  // after k enabled clks: sck toggled k/CLK_DIV times; fall number f lands on
  // frame position (f-1) mod 2*SLOT_W
  task automatic model_step(input bit i);
    int          cd, sw, tg, f, p, b;
    logic        acc;
    logic [15:0] ch;
    cd = cdiv(i);
    sw = slotw(i);
    if (rst || !en) begin
      k[i] = 0; pv[i] = 1'b0; pl[i] = '0; pr[i] = '0; cl[i] = '0; cr[i] = '0;
      e_sck[i] = 1'b0; e_ws[i] = 1'b1; e_sd[i] = 1'b0;
      e_fs[i] = 1'b0; e_ur[i] = 1'b0; e_rdy[i] = 1'b1;
    end else begin
      acc      = s_valid && !pv[i];
      k[i]     = k[i] + 1;
      tg       = k[i] / cd;
      e_sck[i] = (tg % 2) == 1;
      e_fs[i]  = 1'b0;
      e_ur[i]  = 1'b0;
      if ((k[i] % cd == 0) && (tg % 2 == 0)) begin
        f = tg / 2;
        p = (f - 1) % (2 * sw);
        if (p == 0) begin
          e_fs[i] = 1'b1;
          if (pv[i]) begin
            cl[i] = pl[i]; cr[i] = pr[i]; pv[i] = 1'b0;
          end else begin
            cl[i] = '0; cr[i] = '0; e_ur[i] = 1'b1;
          end
        end
        e_ws[i] = (p >= sw);
        b       = p % sw;
        ch      = e_ws[i] ? cr[i] : cl[i];
        ch      = ch >> (16 - b);
        e_sd[i] = (b >= 1 && b <= 16) ? ch[0] : 1'b0;
      end
      if (acc) begin
        pl[i] = s_data_l; pr[i] = s_data_r; pv[i] = 1'b1;
      end
      e_rdy[i] = !pv[i];
    end
  endtask

  task automatic step_check(input bit i);
    model_step(i);
    check_eq($sformatf("outs%0d@k%0d", i, k[i]),
             32'({sck[i], ws[i], sd[i], fs[i], ur[i], rdy[i]}),
             32'({e_sck[i], e_ws[i], e_sd[i], e_fs[i], e_ur[i], e_rdy[i]}));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step_check(1'b0);
    step_check(1'b1);
    if (ur[0]) ur_dut++;
    if (e_ur[0]) ur_mod++;
    if (fs[0]) fs_dut++;
    if (e_fs[0]) fs_mod++;
    if (en && !rst) begin
      if (k[0] == 3) check_eq("sck_low_before_first_rise", 32'(sck[0]), 32'd0);
      if (k[0] == 4) check_eq("first_rise_clk4", 32'({sck[0], ws[0]}), 32'b11);
      if (k[0] == 8) check_eq("first_frame_start_clk8", 32'({fs[0], ws[0]}), 32'b10);
      if (k[1] == 2) check_eq("div1_first_frame_start", 32'(fs[1]), 32'd1);
    end
  endtask

  // mode 0 idle, 1 held valid with incrementing data, 2 sparse random,
  // 3 valid only on the clk of a frame start of instance 0
  task automatic run(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      seq++;
      case (mode)
        1: begin
          s_valid  = 1'b1;
          s_data_l = 16'(seq);
          s_data_r = ~16'(seq);
        end
        2: begin
          s_valid  = ($urandom_range(0, 599) == 0);
          s_data_l = 16'($urandom);
          s_data_r = 16'($urandom);
        end
        3: begin
          s_valid  = fs_next(1'b0);
          s_data_l = 16'($urandom);
          s_data_r = 16'($urandom);
        end
        default: s_valid = 1'b0;
      endcase
      cyc();
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data_l = '0; s_data_r = '0;
    repeat (3) cyc();
    check_eq("reset_state", 32'({sck[0], ws[0], sd[0], fs[0], ur[0], rdy[0]}), 32'b010001);
    rst = 1'b0; en = 1'b1;
    run(20, 3);
    run(1100, 0);
    run(2600, 1);
    run(2000, 2);
    run(1100, 3);
    found = 1'b0;
    for (int n = 0; n < 1200 && !found; n++) begin
      if (k[0] >= 8 && (((k[0] / 8) - 1) % 64) == 40) found = 1'b1;
      else run(1, 2);
    end
    check_eq("reach_bit_cnt40", 32'(found), 32'd1);
    en = 1'b0;
    run(1, 2);
    check_eq("en_drop_outs", 32'({sck[0], ws[0], sd[0], fs[0], ur[0], rdy[0]}), 32'b010001);
    run(5, 2);
    en = 1'b1;
    run(1500, 2);
    run(1000, 1);
    rst = 1'b1;
    run(1, 1);
    check_eq("rst_mid_frame", 32'({sck[0], ws[0], sd[0], fs[0], ur[0], rdy[0]}), 32'b010001);
    rst = 1'b0;
    run(50, 2);
    check_eq("underrun_count", 32'(ur_dut), 32'(ur_mod));
    check_eq("frame_count", 32'(fs_dut), 32'(fs_mod));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
